reserved_parking_entry: RTL and testbench

RESERVED_PARKING_ENTRY -- requirements
Module: reserved_parking_entry

---
 rtl/reserved_parking_entry.sv | 106 ++++++++++
 tb/tb_reserved_parking_entry.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/reserved_parking_entry.sv
// Gate controller for reserved parking: validates entry/exit requests per flat and tracks slot occupancy.
// Every output is registered; the response appears in the cycle after the request is sampled. There is no backpressure and no busy state.
module reserved_parking_entry #(
  parameter  int N = 8,
  localparam int W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         entry_req,
  input  logic         exit_req,
  input  logic         pwd_flag,
  input  logic [W-1:0] flat_number,
  output logic         gate_open,
  output logic         denied,
  output logic [1:0]   deny_code,
  output logic [W-1:0] slot_id,
  output logic [N:0]   occupancy,
  output logic [W-1:0] occupied_count
);

  localparam logic [W-1:0] MAX_FLAT      = W'(N + 1);
  localparam logic [1:0]   CODE_BAD_PWD  = 2'd1;
  localparam logic [1:0]   CODE_BAD_FLAT = 2'd2;
  localparam logic [1:0]   CODE_CONFLICT = 2'd3;

  logic         gate_q, gate_d;
  logic         denied_q, denied_d;
  logic [1:0]   code_q, code_d;
  logic [W-1:0] slot_q, slot_d;
  logic [N:0]   occ_q, occ_d;
  logic [W-1:0] cnt_q, cnt_d;

  logic         is_exit, is_entry, flat_ok, slot_busy;
  logic [N:0]   slot_mask;

  // Exit wins a simultaneous request; the entry is silently dropped.
  assign is_exit  = exit_req;
  assign is_entry = entry_req & ~exit_req;
  assign flat_ok  = (flat_number != '0) && (flat_number <= MAX_FLAT);

  always_comb begin
    slot_mask = '0;
    for (int k = 0; k <= N; k++) begin
      slot_mask[k] = (flat_number == W'(k + 1));
    end
  end

  assign slot_busy = |(occ_q & slot_mask);

  always_comb begin
    gate_d   = 1'b0;
    denied_d = 1'b0;
    code_d   = 2'd0;
    slot_d   = slot_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (is_exit || is_entry) begin
      slot_d = flat_number;
      if (!flat_ok) begin
        denied_d = 1'b1;
        code_d   = CODE_BAD_FLAT;
      end else if (is_entry && !pwd_flag) begin
        denied_d = 1'b1;
        code_d   = CODE_BAD_PWD;
      end else if (is_entry == slot_busy) begin
        // Entering an occupied slot or leaving a vacant one; this also keeps the count from wrapping.
        denied_d = 1'b1;
        code_d   = CODE_CONFLICT;
      end else if (is_entry) begin
        gate_d = 1'b1;
        occ_d  = occ_q | slot_mask;
        cnt_d  = cnt_q + W'(1);
      end else begin
        gate_d = 1'b1;
        occ_d  = occ_q & ~slot_mask;
        cnt_d  = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q   <= 1'b0;
      denied_q <= 1'b0;
      code_q   <= 2'd0;
      slot_q   <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      gate_q   <= gate_d;
      denied_q <= denied_d;
      code_q   <= code_d;
      slot_q   <= slot_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gate_open      = gate_q;
  assign denied         = denied_q;
  assign deny_code      = code_q;
  assign slot_id        = slot_q;
  assign occupancy      = occ_q;
  assign occupied_count = cnt_q;

endmodule

// File: tb/tb_reserved_parking_entry.sv
// Scoreboard bench for reserved_parking_entry: directed requests push expected responses, a negedge monitor pops and compares.
module tb_reserved_parking_entry;

  localparam int N = 8;
  localparam int W = $clog2(N) + 1;

  typedef struct packed {
    logic         gate;
    logic         den;
    logic [1:0]   code;
    logic [W-1:0] slot;
    logic [N:0]   occ;
    logic [W-1:0] cnt;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         entry_req = 1'b0;
  logic         exit_req = 1'b0;
  logic         pwd_flag = 1'b0;
  logic [W-1:0] flat_number = '0;
  logic         gate_open, denied;
  logic [1:0]   deny_code;
  logic [W-1:0] slot_id, occupied_count;
  logic [N:0]   occupancy;

  reserved_parking_entry #(.N(N)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
    .pwd_flag(pwd_flag), .flat_number(flat_number), .gate_open(gate_open),
    .denied(denied), .deny_code(deny_code), .slot_id(slot_id),
    .occupancy(occupancy), .occupied_count(occupied_count)
  );

  always #5 clk = ~clk;

  resp_t exp_q[$];
  resp_t snap_exp;
  int    snap_seq = 0;
  int    snap_seen = 0;
  logic  end_req = 1'b0;
  logic  end_ack = 1'b0;
  int    checks = 0;
  int    errors = 0;

  // Monitor: owns the counters; handles pulses, state snapshots and the final drain check.
  always @(negedge clk) begin
    resp_t got;
    resp_t e;
    got = {gate_open, denied, deny_code, slot_id, occupancy, occupied_count};
    if (gate_open || denied) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got=%h expected no response", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL response got gate=%b den=%b code=%0d slot=%0d occ=%h cnt=%0d expected gate=%b den=%b code=%0d slot=%0d occ=%h cnt=%0d",
                   got.gate, got.den, got.code, got.slot, got.occ, got.cnt,
                   e.gate, e.den, e.code, e.slot, e.occ, e.cnt);
        end
      end
    end
    if (snap_seq != snap_seen) begin
      snap_seen = snap_seq;
      checks++;
      if (got !== snap_exp) begin
        errors++;
        $display("FAIL snapshot%0d got=%h expected=%h", snap_seq, got, snap_exp);
      end
    end
    if (end_req && !end_ack) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_responses got %0d outstanding expected 0", exp_q.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic issue(input logic en, input logic ex, input logic pwd, input logic [W-1:0] f,
                       input logic g, input logic d, input logic [1:0] c, input logic [W-1:0] s,
                       input logic [N:0] o, input logic [W-1:0] n);
    entry_req   = en;
    exit_req    = ex;
    pwd_flag    = pwd;
    flat_number = f;
    exp_q.push_back('{gate: g, den: d, code: c, slot: s, occ: o, cnt: n});
    @(posedge clk);
    #1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic snapshot(input logic [W-1:0] s, input logic [N:0] o, input logic [W-1:0] n);
    snap_exp = '{gate: 1'b0, den: 1'b0, code: 2'd0, slot: s, occ: o, cnt: n};
    snap_seq++;
  endtask

  initial begin
    idle(3);
    snapshot('0, '0, '0);
    rst = 1'b0;
    idle(1);

    // Accept, bad password, invalid flats (including one above N+1 and one where invalid outranks bad password).
    issue(1, 0, 1, 4'd3,  1, 0, 2'd0, 4'd3,  9'h004, 4'd1);
    issue(1, 0, 0, 4'd3,  0, 1, 2'd1, 4'd3,  9'h004, 4'd1);
    issue(1, 0, 1, 4'd0,  0, 1, 2'd2, 4'd0,  9'h004, 4'd1);
    issue(1, 0, 1, 4'd10, 0, 1, 2'd2, 4'd10, 9'h004, 4'd1);
    issue(1, 0, 0, 4'd15, 0, 1, 2'd2, 4'd15, 9'h004, 4'd1);
    issue(1, 0, 1, 4'd3,  0, 1, 2'd3, 4'd3,  9'h004, 4'd1);
    issue(0, 1, 0, 4'd3,  1, 0, 2'd0, 4'd3,  9'h000, 4'd0);
    issue(0, 1, 1, 4'd0,  0, 1, 2'd2, 4'd0,  9'h000, 4'd0);
    issue(0, 1, 1, 4'd3,  0, 1, 2'd3, 4'd3,  9'h000, 4'd0);
    idle(2);
    snapshot(4'd3, 9'h000, 4'd0);
    idle(1);

    // Fill every slot back to back, then probe the full and simultaneous-request corners.
    for (int f = 1; f <= N + 1; f++) begin
      logic [N:0] occ_exp;
      occ_exp = (N + 1)'((1 << f) - 1);
      issue(1, 0, 1, W'(f), 1, 0, 2'd0, W'(f), occ_exp, W'(f));
    end
    issue(1, 0, 1, 4'd9, 0, 1, 2'd3, 4'd9, 9'h1FF, 4'd9);
    issue(1, 1, 1, 4'd1, 1, 0, 2'd0, 4'd1, 9'h1FE, 4'd8);
    issue(1, 1, 1, 4'd1, 0, 1, 2'd3, 4'd1, 9'h1FE, 4'd8);
    issue(0, 1, 0, 4'd9, 1, 0, 2'd0, 4'd9, 9'h0FE, 4'd7);
    idle(1);

    // Reset with slots occupied and a request pending: the request must vanish.
    rst = 1'b1;
    entry_req = 1'b1;
    pwd_flag = 1'b1;
    flat_number = 4'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    entry_req = 1'b0;
    snapshot('0, '0, '0);
    idle(1);
    issue(1, 0, 1, 4'd2, 1, 0, 2'd0, 4'd2, 9'h002, 4'd1);
    issue(1, 0, 1, 4'd5, 1, 0, 2'd0, 4'd5, 9'h012, 4'd2);
    idle(3);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(posedge clk);
    if (!end_ack) begin
      $display("FAIL monitor_timeout got no drain acknowledgement expected one within 10 cycles");
      $fatal(1, "monitor did not respond");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
